// File: rtl/uart_rx_edge_sampler_if.sv
// Handshake bundle between the RX FSM / deserializer (master) and the edge sampler (slave).
interface uart_rx_edge_sampler_if #(
    parameter int PRESCALE_WIDTH = 6,
    parameter int BIT_CNT_WIDTH  = 4
);
    logic                      samp_en;
    logic [PRESCALE_WIDTH-1:0] Prescale;
    logic                      rx_sync;
    logic [PRESCALE_WIDTH-1:0] edge_cnt;
    logic [BIT_CNT_WIDTH-1:0]  bit_cnt;
    logic                      sampled_bit;
    logic                      sample_valid;

    modport master (
        output samp_en, Prescale,
        input  rx_sync, edge_cnt, bit_cnt, sampled_bit, sample_valid
    );

    modport slave (
        input  samp_en, Prescale,
        output rx_sync, edge_cnt, bit_cnt, sampled_bit, sample_valid
    );
endinterface

// File: rtl/uart_rx_edge_sampler.sv
// UART RX front end: 2-flop line synchronizer, oversample/bit counters and
// a three-sample mid-bit majority vote.
module uart_rx_edge_sampler #(
    parameter int PRESCALE_WIDTH = 6,
    parameter int BIT_CNT_WIDTH  = 4,
    parameter int FRAME_BITS     = 11
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    uart_rx_edge_sampler_if.slave bus
);
    localparam int PW = PRESCALE_WIDTH;
    localparam int BW = BIT_CNT_WIDTH;
    localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_BITS - 1);

    logic          sync1_q, sync2_q;
    logic          s0_q, s0_d, s1_q, s1_d, s2_q, s2_d;
    logic          sampled_q, sampled_d;
    logic          valid_q, valid_d;
    logic [PW-1:0] edge_q, edge_d;
    logic [BW-1:0] bit_q, bit_d;

    logic [PW-1:0] mid, last_edge;
    logic          vote;

    assign mid       = bus.Prescale >> 1;
    assign last_edge = bus.Prescale - PW'(1);
    assign vote      = (s0_q & s1_q) | (s0_q & s2_q) | (s1_q & s2_q);

    always_comb begin
        // NOTE: every next-state signal gets a hold/default value first so no path can infer a latch.
        edge_d    = edge_q;
        bit_d     = bit_q;
        s0_d      = s0_q;
        s1_d      = s1_q;
        s2_d      = s2_q;
        sampled_d = sampled_q;
        valid_d   = 1'b0;

        if (!bus.samp_en) begin
            edge_d = '0;
            bit_d  = '0;
        end else begin
            // >= rather than == so a Prescale lowered mid-bit still wraps.
            if (edge_q >= last_edge) begin
                edge_d = '0;
                bit_d  = (bit_q >= LAST_BIT) ? '0 : bit_q + BW'(1);
            end else begin
                edge_d = edge_q + PW'(1);
            end

            if (edge_q == mid - PW'(2)) s0_d = sync2_q;
            if (edge_q == mid - PW'(1)) s1_d = sync2_q;
            if (edge_q == mid)          s2_d = sync2_q;
            if (edge_q == mid + PW'(1)) begin
                sampled_d = vote;
                valid_d   = 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            s0_q      <= 1'b1;
            s1_q      <= 1'b1;
            s2_q      <= 1'b1;
            sampled_q <= 1'b1;
            valid_q   <= 1'b0;
            edge_q    <= '0;
            bit_q     <= '0;
        end else begin
            sync1_q   <= RX_IN;
            sync2_q   <= sync1_q;
            s0_q      <= s0_d;
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            sampled_q <= sampled_d;
            valid_q   <= valid_d;
            edge_q    <= edge_d;
            bit_q     <= bit_d;
        end
    end

    assign bus.rx_sync      = sync2_q;
    assign bus.edge_cnt     = edge_q;
    assign bus.bit_cnt      = bit_q;
    assign bus.sampled_bit  = sampled_q;
    assign bus.sample_valid = valid_q;
endmodule

// File: tb/tb_uart_rx_edge_sampler.sv
// Directed bench for uart_rx_edge_sampler: reset, counting, majority vote,
// frame wrap, samp_en abort, full frame decode and async reset.
module tb_uart_rx_edge_sampler;
    localparam int PW = 6;
    localparam int BW = 4;
    localparam int FB = 11;

    logic CLK   = 1'b0;
    logic RST   = 1'b0;
    logic RX_IN = 1'b1;

    uart_rx_edge_sampler_if #(.PRESCALE_WIDTH(PW), .BIT_CNT_WIDTH(BW)) bus ();

    uart_rx_edge_sampler #(.PRESCALE_WIDTH(PW), .BIT_CNT_WIDTH(BW), .FRAME_BITS(FB)) dut (
        .CLK  (CLK),
        .RST  (RST),
        .RX_IN(RX_IN),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   valid_cnt;
    logic line_a   [0:1023];
    logic got_bits [0:15];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic fill_line(input logic v);
        for (int i = 0; i < 1024; i++) line_a[i] = v;
    endtask

    // Two idle cycles preload the synchronizer so rx_sync == line_a[0] at edge 0.
    task automatic restart(input int p);
        bus.samp_en  = 1'b0;
        bus.Prescale = PW'(p);
        RX_IN = line_a[0];
        step();
        RX_IN = line_a[1];
        step();
        check("restart_edge", 32'(bus.edge_cnt), 0);
        check("restart_bit", 32'(bus.bit_cnt), 0);
        check("restart_rx_sync", 32'(bus.rx_sync), 32'(line_a[0]));
    endtask

    // Cycle t shows edge t%p of bit t/p; RX_IN is driven two cycles ahead of rx_sync.
    task automatic run(input int p, input int n);
        int mid;
        mid = p >> 1;
        valid_cnt = 0;
        for (int t = 0; t < n; t++) begin
            check("run_edge", 32'(bus.edge_cnt), t % p);
            check("run_bit", 32'(bus.bit_cnt), (t / p) % FB);
            check("run_valid", 32'(bus.sample_valid), ((t % p) == mid + 2) ? 1 : 0);
            check("run_rx_sync", 32'(bus.rx_sync), 32'(line_a[t]));
            if (bus.sample_valid) valid_cnt++;
            if ((t % p) == p - 1) got_bits[(t / p) % 16] = bus.sampled_bit;
            bus.samp_en = 1'b1;
            RX_IN = line_a[t + 2];
            step();
        end
    endtask

    logic [10:0] frame;
    logic [7:0]  p_data;

    initial begin
        bus.samp_en  = 1'b1;
        bus.Prescale = PW'(8);
        RX_IN        = 1'b0;
        RST          = 1'b0;
        fill_line(1'b1);

        // Reset state held with RX_IN low and samp_en high.
        repeat (3) step();
        check("rst_rx_sync", 32'(bus.rx_sync), 1);
        check("rst_sampled", 32'(bus.sampled_bit), 1);
        check("rst_edge", 32'(bus.edge_cnt), 0);
        check("rst_bit", 32'(bus.bit_cnt), 0);
        check("rst_valid", 32'(bus.sample_valid), 0);

        // Release: first count on the first edge; rx_sync lags RX_IN by two edges.
        RST = 1'b1;
        step();
        check("rel_edge1", 32'(bus.edge_cnt), 1);
        check("rel_rx_sync1", 32'(bus.rx_sync), 1);
        step();
        check("rel_edge2", 32'(bus.edge_cnt), 2);
        check("rel_rx_sync2", 32'(bus.rx_sync), 0);

        // Prescale 8, line low: vote resolves to 0.
        fill_line(1'b0);
        restart(8);
        check("p8_sampled_pre", 32'(bus.sampled_bit), 1);
        run(8, 16);
        check("p8_bit0", 32'(got_bits[0]), 0);
        check("p8_bit1", 32'(got_bits[1]), 0);

        // Prescale 16: vote window is edges 6,7,8.
        fill_line(1'b0); line_a[6] = 1'b1; line_a[7] = 1'b1;
        restart(16); run(16, 16);
        check("p16_ones_6_7", 32'(got_bits[0]), 1);

        fill_line(1'b0); line_a[5] = 1'b1; line_a[9] = 1'b1;
        restart(16); run(16, 16);
        check("p16_ones_5_9", 32'(got_bits[0]), 0);

        fill_line(1'b0); line_a[7] = 1'b1; line_a[8] = 1'b1;
        restart(16); run(16, 16);
        check("p16_ones_7_8", 32'(got_bits[0]), 1);

        fill_line(1'b0); line_a[7] = 1'b1;
        restart(16); run(16, 16);
        check("p16_single_7", 32'(got_bits[0]), 0);

        // Full frame at Prescale 8: bit_cnt wraps 10->0 with edge 7->0, 11 strobes.
        fill_line(1'b1);
        restart(8); run(8, 89);
        check("wrap_valid_cnt", valid_cnt, 11);
        check("wrap_bit_after", 32'(bus.bit_cnt), 0);

        // Abort: bit 0 samples 1, bit 1 dropped at edge 5.
        fill_line(1'b0);
        for (int i = 0; i < 16; i++) line_a[i] = 1'b1;
        restart(16); run(16, 21);
        check("abort_bit0", 32'(got_bits[0]), 1);
        check("abort_pre_edge", 32'(bus.edge_cnt), 5);
        bus.samp_en = 1'b0;
        RX_IN = 1'b0;
        step();
        check("abort_edge", 32'(bus.edge_cnt), 0);
        check("abort_bit", 32'(bus.bit_cnt), 0);
        check("abort_sampled", 32'(bus.sampled_bit), 1);
        valid_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.sample_valid) valid_cnt++;
            step();
        end
        check("abort_no_valid", valid_cnt, 0);
        check("abort_hold_edge", 32'(bus.edge_cnt), 0);
        check("abort_hold_sampled", 32'(bus.sampled_bit), 1);
        bus.samp_en = 1'b1;
        step();
        check("reen_edge", 32'(bus.edge_cnt), 1);
        check("reen_bit", 32'(bus.bit_cnt), 0);

        // Prescale 32 frame: start 0, 0xA5 LSB-first, parity 0, stop 1.
        frame = 11'b1_0_10100101_0;
        fill_line(1'b1);
        for (int i = 0; i < 352; i++) line_a[i] = frame[i / 32];
        restart(32); run(32, 352);
        for (int b = 0; b < FB; b++) check($sformatf("frame_bit%0d", b), 32'(got_bits[b]), 32'(frame[b]));
        for (int i = 0; i < 8; i++) p_data[i] = got_bits[i + 1];
        check("p_data", 32'(p_data), 32'hA5);

        // Prescale lowered mid-bit: counter must wrap on the next edge.
        fill_line(1'b1);
        restart(32); run(32, 20);
        bus.Prescale = PW'(8);
        step();
        check("lower_edge", 32'(bus.edge_cnt), 0);
        check("lower_bit", 32'(bus.bit_cnt), 1);
        step();
        check("lower_edge_next", 32'(bus.edge_cnt), 1);

        // Asynchronous reset takes effect without a clock edge.
        step(); step();
        check("pre_async_edge", 32'(bus.edge_cnt), 3);
        RST = 1'b0;
        #1;
        check("async_edge", 32'(bus.edge_cnt), 0);
        check("async_bit", 32'(bus.bit_cnt), 0);
        check("async_rx_sync", 32'(bus.rx_sync), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
